game_flow_ctrl: RTL and testbench

//  Frame-based game sequencer: title -> get-ready -> play -> dying -> respawn/game-over.

---
 rtl/game_flow_ctrl.sv | 159 +++++++++++++++
 tb/tb_game_flow_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//   Frame-based game sequencer: TITLE -> READY -> PLAY -> DYING -> READY / OVER.
//   Owns all game-phase timing. Every duration is counted in vsync_pulse ticks.
//   Outputs are registered and decoded from the current state, so an input
//   event changes state one clock later and the outputs follow one clock after
//   that. The new_level / respawn pulses are registered off the READY->PLAY
//   edge itself and are high for the single cycle that follows it.
//
// Ports
//   clk_25       in   1        system clock
//   resetN       in   1        asynchronous active-low reset
//   vsync_pulse  in   1        one-cycle pulse per frame
//   die          in   1        collision (level), honoured only in PLAY
//   lives        in   LIVES_W  remaining lives, already decremented upstream
//   level_clear  in   1        all asteroids destroyed (level), only in PLAY
//   title_en     out  1        draw the title banner
//   title_scale  out  8        title zoom factor
//   game_begin   out  1        high only in PLAY
//   ship_en      out  1        ship drawn and collidable
//   new_level    out  1        one-cycle pulse: spawn a fresh asteroid wave
//   respawn      out  1        one-cycle pulse: recentre the ship
//   game_over    out  1        sticky game-over flag
//   level        out  LEVEL_W  current level, starts at 1, saturates
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
  parameter int TITLE_FRAMES = 256,
  parameter int READY_FRAMES = 128,
  parameter int DYING_FRAMES = 120,
  parameter int LIVES_W      = 4,
  parameter int LEVEL_W      = 4
) (
  input  logic               clk_25,
  input  logic               resetN,
  input  logic               vsync_pulse,
  input  logic               die,
  input  logic [LIVES_W-1:0] lives,
  input  logic               level_clear,
  output logic               title_en,
  output logic [7:0]         title_scale,
  output logic               game_begin,
  output logic               ship_en,
  output logic               new_level,
  output logic               respawn,
  output logic               game_over,
  output logic [LEVEL_W-1:0] level
);

  localparam int MAX_FRAMES =
    (TITLE_FRAMES > READY_FRAMES)
      ? ((TITLE_FRAMES > DYING_FRAMES) ? TITLE_FRAMES : DYING_FRAMES)
      : ((READY_FRAMES > DYING_FRAMES) ? READY_FRAMES : DYING_FRAMES);
  localparam int CNT_W = $clog2(MAX_FRAMES);

  localparam logic [CNT_W-1:0] TITLE_LAST = CNT_W'(TITLE_FRAMES - 1);
  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_FRAMES - 1);
  localparam logic [CNT_W-1:0] DYING_LAST = CNT_W'(DYING_FRAMES - 1);

  typedef enum logic [2:0] {
    S_TITLE,
    S_READY,
    S_PLAY,
    S_DYING,
    S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEVEL_W-1:0] level_d;
  logic               pend_q, pend_d;
  logic               new_level_d, respawn_d;
  logic [31:0]        cnt_wide;
  logic [7:0]         scale_sat;

  // Title zoom follows the frame counter but never wraps past 8'hFF.
  assign cnt_wide  = {{(32-CNT_W){1'b0}}, cnt_q};
  assign scale_sat = (|cnt_wide[31:8]) ? 8'hFF : cnt_wide[7:0];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    level_d     = level;
    pend_d      = pend_q;
    new_level_d = 1'b0;
    respawn_d   = 1'b0;

    unique case (state_q)
      S_TITLE: if (vsync_pulse && cnt_q == TITLE_LAST) state_d = S_READY;
      S_READY: begin
        if (vsync_pulse && cnt_q == READY_LAST) begin
          state_d     = S_PLAY;
          respawn_d   = 1'b1;
          new_level_d = pend_q;
          pend_d      = 1'b0;
        end
      end
      S_PLAY: begin
        // die has priority: a simultaneous level_clear is discarded.
        if (die) begin
          state_d = S_DYING;
        end else if (level_clear) begin
          state_d = S_READY;
          pend_d  = 1'b1;
          if (level != '1) level_d = level + LEVEL_W'(1);
        end
      end
      S_DYING: begin
        // lives is looked at only now, after the death pause has elapsed.
        if (vsync_pulse && cnt_q == DYING_LAST) begin
          if (lives == '0) begin
            state_d = S_OVER;
          end else begin
            state_d = S_READY;
            pend_d  = 1'b0;
          end
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_TITLE;
    endcase

    // Counter restarts on every state entry, otherwise counts frames.
    if (state_d != state_q)  cnt_d = '0;
    else if (vsync_pulse)    cnt_d = cnt_q + CNT_W'(1);
    else                     cnt_d = cnt_q;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_TITLE;
      cnt_q       <= '0;
      level       <= LEVEL_W'(1);
      pend_q      <= 1'b1;
      new_level   <= 1'b0;
      respawn     <= 1'b0;
      title_en    <= 1'b1;
      title_scale <= 8'h00;
      game_begin  <= 1'b0;
      ship_en     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level       <= level_d;
      pend_q      <= pend_d;
      new_level   <= new_level_d;
      respawn     <= respawn_d;
      title_en    <= (state_q == S_TITLE);
      title_scale <= (state_q == S_TITLE) ? scale_sat : 8'h00;
      game_begin  <= (state_q == S_PLAY);
      ship_en     <= (state_q == S_READY) || (state_q == S_PLAY);
      game_over   <= (state_q == S_OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
//   Self-checking bench for game_flow_ctrl. A phase/frame-count model of the
//   game flow predicts every output each cycle; directed sequences walk the
//   title, death, last-life, level-clear and reset scenarios, and a random
//   section exercises die / level_clear / lives / vsync combinations.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

  localparam int TF        = 256;
  localparam int RF        = 128;
  localparam int DF        = 120;
  localparam int LEVEL_MAX = 15;

  logic       clk_25      = 1'b0;
  logic       resetN      = 1'b0;
  logic       vsync_pulse = 1'b0;
  logic       die         = 1'b0;
  logic       level_clear = 1'b0;
  logic [3:0] lives       = 4'd2;

  logic       title_en, game_begin, ship_en, new_level, respawn, game_over;
  logic [7:0] title_scale;
  logic [3:0] level;

  game_flow_ctrl #(
    .TITLE_FRAMES(TF), .READY_FRAMES(RF), .DYING_FRAMES(DF),
    .LIVES_W(4), .LEVEL_W(4)
  ) dut (
    .clk_25(clk_25), .resetN(resetN), .vsync_pulse(vsync_pulse), .die(die),
    .lives(lives), .level_clear(level_clear), .title_en(title_en),
    .title_scale(title_scale), .game_begin(game_begin), .ship_en(ship_en),
    .new_level(new_level), .respawn(respawn), .game_over(game_over),
    .level(level)
  );

  always #20 clk_25 = ~clk_25;

  int checks   = 0;
  int failures = 0;

  // Model: which phase the game is in and how many frames it has lasted.
  typedef enum int {P_TITLE, P_READY, P_PLAY, P_DYING, P_OVER} phase_t;
  phase_t m_phase;
  int     m_frames;
  int     m_level;
  bit     m_pend;
  bit     e_title_en, e_begin, e_ship, e_new, e_resp, e_over;
  int     e_scale;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_TITLE; m_frames = 0; m_level = 1; m_pend = 1'b1;
    e_title_en = 1'b1; e_scale = 0; e_begin = 1'b0; e_ship = 1'b0;
    e_new = 1'b0; e_resp = 1'b0; e_over = 1'b0;
  endtask

  task automatic compare_all();
    check("title_en",    32'(title_en),    32'(e_title_en));
    check("title_scale", 32'(title_scale), 32'(e_scale));
    check("game_begin",  32'(game_begin),  32'(e_begin));
    check("ship_en",     32'(ship_en),     32'(e_ship));
    check("new_level",   32'(new_level),   32'(e_new));
    check("respawn",     32'(respawn),     32'(e_resp));
    check("game_over",   32'(game_over),   32'(e_over));
    check("level",       32'(level),       32'(m_level));
  endtask

  // One clock: the model advances at the edge with the same inputs the DUT
  // sees, then all outputs are compared at the following falling edge.
  task automatic cycle();
    phase_t old_p;
    int     old_f;
    @(posedge clk_25);
    old_p = m_phase;
    old_f = m_frames;
    // Outputs visible after this edge reflect the phase held before it.
    e_title_en = (old_p == P_TITLE);
    e_scale    = (old_p == P_TITLE) ? ((old_f > 255) ? 255 : old_f) : 0;
    e_ship     = (old_p == P_READY) || (old_p == P_PLAY);
    e_begin    = (old_p == P_PLAY);
    e_over     = (old_p == P_OVER);
    e_new      = 1'b0;
    e_resp     = 1'b0;
    case (old_p)
      P_TITLE: if (vsync_pulse && old_f == TF - 1) m_phase = P_READY;
      P_READY: if (vsync_pulse && old_f == RF - 1) begin
        m_phase = P_PLAY;
        e_resp  = 1'b1;
        e_new   = m_pend;
        m_pend  = 1'b0;
      end
      P_PLAY: begin
        if (die) m_phase = P_DYING;
        else if (level_clear) begin
          m_phase = P_READY;
          m_pend  = 1'b1;
          if (m_level < LEVEL_MAX) m_level = m_level + 1;
        end
      end
      P_DYING: if (vsync_pulse && old_f == DF - 1) begin
        if (lives == 4'd0) m_phase = P_OVER;
        else begin
          m_phase = P_READY;
          m_pend  = 1'b0;
        end
      end
      default: ;
    endcase
    if (m_phase != old_p) m_frames = 0;
    else if (vsync_pulse) m_frames = m_frames + 1;
    @(negedge clk_25);
    compare_all();
  endtask

  task automatic drive(input bit vs, input bit d, input bit lc);
    vsync_pulse = vs; die = d; level_clear = lc;
    cycle();
  endtask

  // Runs until the model reaches 'target'. With noise set, die/level_clear
  // toggle randomly outside PLAY, where they must be ignored.
  task automatic run_until(input phase_t target, input int budget,
                           input int vs_pct, input bit noise);
    int n = 0;
    while (m_phase != target && n < budget) begin
      vsync_pulse = ($urandom_range(0, 99) < vs_pct);
      if (noise && m_phase != P_PLAY) begin
        die         = 1'($urandom_range(0, 1));
        level_clear = 1'($urandom_range(0, 1));
      end else begin
        die = 1'b0; level_clear = 1'b0;
      end
      cycle();
      n++;
    end
    die = 1'b0; level_clear = 1'b0; vsync_pulse = 1'b0;
    checks++;
    if (m_phase != target) begin
      failures++;
      $display("FAIL timeout waiting for %s: still in %s after %0d cycles",
               target.name(), m_phase.name(), n);
    end
  endtask

  // Asserts reset a few ns after a falling edge; outputs must be at their
  // reset values right away, without waiting for a clock.
  task automatic apply_reset();
    #5;
    resetN = 1'b0;
    vsync_pulse = 1'b0; die = 1'b0; level_clear = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_async_title_en", 32'(title_en), 32'd1);
    check("rst_async_game_over", 32'(game_over), 32'd0);
    @(negedge clk_25);
    @(negedge clk_25);
    compare_all();
    resetN = 1'b1;
  endtask

  initial begin
    model_reset();
    // T1: reset state
    repeat (2) @(negedge clk_25);
    compare_all();
    check("t1_title_en", 32'(title_en), 32'd1);
    check("t1_title_scale", 32'(title_scale), 32'd0);
    check("t1_level", 32'(level), 32'd1);
    resetN = 1'b1;

    // T2: title zoom after exactly 10 frames, then on to READY and PLAY
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check("t2_scale_10", 32'(title_scale), 32'd10);
    run_until(P_READY, 2000, 50, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    check("t2_title_off", 32'(title_en), 32'd0);
    check("t2_ship_on", 32'(ship_en), 32'd1);
    run_until(P_PLAY, 1000, 50, 1'b1);
    check("t2_new_level_pulse", 32'(new_level), 32'd1);
    check("t2_respawn_pulse", 32'(respawn), 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    check("t2_new_level_drop", 32'(new_level), 32'd0);
    check("t2_game_begin", 32'(game_begin), 32'd1);

    // T3: death with lives remaining; die coincides with vsync
    lives = 4'd2;
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t3_begin_off", 32'(game_begin), 32'd0);
    check("t3_ship_off", 32'(ship_en), 32'd0);
    run_until(P_READY, 1000, 50, 1'b1);
    run_until(P_PLAY, 1000, 50, 1'b1);
    check("t3_respawn_only", 32'(respawn), 32'd1);
    check("t3_no_new_level", 32'(new_level), 32'd0);
    check("t3_level_same", 32'(level), 32'd1);

    // T5: level clear, then die + level_clear together, then held die
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    run_until(P_PLAY, 1000, 50, 1'b1);
    check("t5_new_level", 32'(new_level), 32'd1);
    check("t5_level_2", 32'(level), 32'd2);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("t5_die_wins_level", 32'(level), 32'd2);
    check("t5_die_wins_ship", 32'(ship_en), 32'd0);
    lives = 4'd1;
    run_until(P_READY, 1000, 50, 1'b1);
    run_until(P_PLAY, 1000, 50, 1'b1);
    repeat (6) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    die = 1'b0;

    // Random play: lives wander, die/level_clear rare in PLAY
    for (int i = 0; i < 6000 && m_phase != P_OVER; i++) begin
      vsync_pulse = ($urandom_range(0, 99) < 50);
      lives       = 4'($urandom_range(0, 3));
      die         = ($urandom_range(0, 99) < 2);
      level_clear = ($urandom_range(0, 99) < 2);
      cycle();
    end
    die = 1'b0; level_clear = 1'b0;
    @(negedge clk_25);
    apply_reset();

    // T4: last life -> sticky game over, reset returns to TITLE
    run_until(P_PLAY, 1000, 100, 1'b0);
    lives = 4'd0;
    drive(1'b0, 1'b1, 1'b0);
    run_until(P_OVER, 1000, 100, 1'b1);
    for (int i = 0; i < 1000; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("t4_game_over_sticky", 32'(game_over), 32'd1);
    check("t4_ship_off", 32'(ship_en), 32'd0);
    apply_reset();
    drive(1'b0, 1'b0, 1'b0);
    check("t4_back_to_title", 32'(title_en), 32'd1);

    // Level saturation at all-ones
    lives = 4'd3;
    run_until(P_PLAY, 1000, 100, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      run_until(P_PLAY, 500, 100, 1'b0);
    end
    check("level_saturated", 32'(level), 32'd15);

    // T6: reset asserted in the middle of DYING
    drive(1'b1, 1'b1, 1'b0);
    repeat (20) drive(1'b1, 1'b0, 1'b0);
    apply_reset();
    repeat (5) drive(1'b1, 1'b1, 1'b1);
    check("t6_title_after_reset", 32'(title_en), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
